// File: rtl/paddle_game_ctrl_pkg.sv
// Shared game definitions for the paddle, ball and brick logic.
// State encodings, move command codes and screen geometry.
package paddle_game_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        SERVE = 3'b001,
        PLAY  = 3'b010,
        LOST  = 3'b011,
        WIN   = 3'b100
    } game_state_t;

    localparam logic [7:0] MOVE_RIGHT = 8'h00;
    localparam logic [7:0] MOVE_LEFT  = 8'h01;
    localparam logic [7:0] MOVE_NONE  = 8'hFF;

    localparam int SCREEN_W = 160;

    // Conflicting or absent keys both mean "stay put".
    function automatic logic [7:0] encode_move(input logic left, input logic right);
        logic [7:0] cmd;
        cmd = MOVE_NONE;
        if (left && !right) begin
            cmd = MOVE_LEFT;
        end else if (right && !left) begin
            cmd = MOVE_RIGHT;
        end
        return cmd;
    endfunction

    function automatic logic is_active(input game_state_t s);
        return (s == SERVE) || (s == PLAY);
    endfunction

endpackage

// File: rtl/paddle_game_ctrl_tick_divider.sv
// Free-running divider: one-cycle registered tick every TICK_DIV clocks while run is high.
// Counter parks at zero whenever run is low, so each run period starts with a full interval.
module tick_divider #(
    parameter int TICK_DIV = 500000
) (
    input  logic i_clock,
    input  logic i_resetn,
    input  logic i_run,
    output logic o_tick
);

    localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (!i_run) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/paddle_game_ctrl.sv
// Game sequencer: state FSM, lives tracking, movement tick and key-to-command encoding.
// All outputs registered (move_en/move_cmd gated by the registered state).
module paddle_game_ctrl
    import paddle_game_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int LIVES    = 3
) (
    input  logic       i_clock,
    input  logic       i_resetn,
    input  logic       i_start,
    input  logic       i_key_left,
    input  logic       i_key_right,
    input  logic       i_ball_lost,
    input  logic       i_bricks_cleared,
    output logic [2:0] o_state,
    output logic       o_move_en,
    output logic [7:0] o_move_cmd,
    output logic [2:0] o_lives
);

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);

    game_state_t r_state;
    game_state_t w_state_nxt;
    logic [2:0]  r_lives;
    logic [2:0]  w_lives_nxt;
    logic        r_start_q;
    logic [7:0]  r_move_cmd;
    logic        w_start_pulse;
    logic        w_run;
    logic        w_tick;

    assign w_start_pulse = i_start & ~r_start_q;
    assign w_run         = is_active(r_state);

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= IDLE;
            r_lives    <= 3'd0;
            r_start_q  <= 1'b0;
            r_move_cmd <= MOVE_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_lives    <= w_lives_nxt;
            r_start_q  <= i_start;
            r_move_cmd <= encode_move(i_key_left, i_key_right);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        case (r_state)
            IDLE: begin
                if (w_start_pulse) begin
                    w_state_nxt = SERVE;
                    w_lives_nxt = LIVES_INIT;
                end
            end
            SERVE: begin
                if (w_start_pulse) begin
                    w_state_nxt = PLAY;
                end
            end
            PLAY: begin
                // Clearing the board wins even if the ball is lost the same cycle.
                if (i_bricks_cleared) begin
                    w_state_nxt = WIN;
                end else if (i_ball_lost) begin
                    if (r_lives == 3'd1) begin
                        w_state_nxt = LOST;
                        w_lives_nxt = 3'd0;
                    end else begin
                        w_state_nxt = SERVE;
                        w_lives_nxt = r_lives - 3'd1;
                    end
                end
            end
            LOST, WIN: begin
                if (w_start_pulse) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .i_clock  (i_clock),
        .i_resetn (i_resetn),
        .i_run    (w_run),
        .o_tick   (w_tick)
    );

    // A tick landing on the edge that leaves SERVE/PLAY is suppressed.
    assign o_state    = r_state;
    assign o_move_en  = w_tick & w_run;
    assign o_move_cmd = w_run ? r_move_cmd : MOVE_NONE;
    assign o_lives    = r_lives;

endmodule
